// File: rtl/exu_fpu_wb_ctl.sv
// exu_fpu_wb_ctl: in-order FP writeback control, pairs FPU finishes with issued rd and shares the FP regfile write port with loads
//   clk, rst (async, active-high)
//   issue_valid/issue_rd/issue_stall          : issue-side tag push and back-pressure
//   fpu_finish/fpu_result/fpu_fflags          : in-order FPU completion
//   flush_lower                               : discards unfinished tags and ignores issue/finish this cycle
//   lsu_fp_wen/lsu_fp_waddr/lsu_fp_wdata      : FP load writeback (highest priority)
//   fpr_wen/fpr_waddr/fpr_wdata               : FP regfile write port
//   fflags_wen/fflags_acc                     : accrued-flags pulse for written FPU results
//   fpr_pending                               : per-register outstanding-write scoreboard
//   wb_error                                  : sticky protocol-error flag
module exu_fpu_wb_ctl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_stall,
    input  logic        fpu_finish,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  fpu_fflags,
    input  logic        flush_lower,
    input  logic        lsu_fp_wen,
    input  logic [4:0]  lsu_fp_waddr,
    input  logic [31:0] lsu_fp_wdata,
    output logic        fpr_wen,
    output logic [4:0]  fpr_waddr,
    output logic [31:0] fpr_wdata,
    output logic        fflags_wen,
    output logic [4:0]  fflags_acc,
    output logic [31:0] fpr_pending,
    output logic        wb_error
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]    tag_rd [DEPTH];
    logic [PW-1:0] tag_wp, tag_rp;
    logic [CW-1:0] tag_cnt;
    logic [4:0]    res_rd [DEPTH];
    logic [31:0]   res_data [DEPTH];
    logic [4:0]    res_ff [DEPTH];
    logic [PW-1:0] res_wp, res_rp;
    logic [CW-1:0] res_cnt;

    logic lsu_w, fin_ok, tag_push, res_ne, res_pop, res_push, bypass;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // reset gates the load path too so every output reads 0 while rst is high
    assign lsu_w       = lsu_fp_wen & ~rst;
    assign fin_ok      = fpu_finish & ~flush_lower & (tag_cnt != '0);
    assign issue_stall = ({1'b0, tag_cnt} + {1'b0, res_cnt}) == (CW + 1)'(DEPTH);
    assign tag_push    = issue_valid & ~flush_lower & ~issue_stall;
    assign res_ne      = res_cnt != '0;
    assign res_pop     = ~lsu_w & res_ne;
    assign res_push    = fin_ok & (lsu_w | res_ne);
    assign bypass      = ~lsu_w & ~res_ne & fin_ok;

    assign fpr_wen    = lsu_w | res_ne | fin_ok;
    assign fpr_waddr  = lsu_w ? lsu_fp_waddr : res_ne ? res_rd[res_rp] : bypass ? tag_rd[tag_rp] : 5'd0;
    assign fpr_wdata  = lsu_w ? lsu_fp_wdata : res_ne ? res_data[res_rp] : bypass ? fpu_result : 32'd0;
    assign fflags_wen = ~lsu_w & (res_ne | fin_ok);
    assign fflags_acc = ~fflags_wen ? 5'd0 : res_ne ? res_ff[res_rp] : fpu_fflags;

    always_comb begin
        fpr_pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int t, r;
            t = int'(tag_rp) + k;
            r = int'(res_rp) + k;
            t = (t >= DEPTH) ? t - DEPTH : t;
            r = (r >= DEPTH) ? r - DEPTH : r;
            if (k < int'(tag_cnt)) fpr_pending[tag_rd[t]] = 1'b1;
            if (k < int'(res_cnt)) fpr_pending[res_rd[r]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) tag_rd[tag_wp] <= issue_rd;
        if (res_push) begin
            res_rd[res_wp]   <= tag_rd[tag_rp];
            res_data[res_wp] <= fpu_result;
            res_ff[res_wp]   <= fpu_fflags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wp   <= '0;
            tag_rp   <= '0;
            tag_cnt  <= '0;
            res_wp   <= '0;
            res_rp   <= '0;
            res_cnt  <= '0;
            wb_error <= 1'b0;
        end else begin
            if (flush_lower) begin
                tag_wp  <= '0;
                tag_rp  <= '0;
                tag_cnt <= '0;
            end else begin
                if (tag_push) tag_wp <= inc(tag_wp);
                if (fin_ok) tag_rp <= inc(tag_rp);
                tag_cnt <= tag_cnt + CW'(tag_push) - CW'(fin_ok);
            end
            if (res_push) res_wp <= inc(res_wp);
            if (res_pop) res_rp <= inc(res_rp);
            res_cnt  <= res_cnt + CW'(res_push) - CW'(res_pop);
            wb_error <= wb_error
                      | (fpu_finish & ~flush_lower & (tag_cnt == '0))
                      | (issue_valid & issue_stall)
                      | (lsu_fp_wen & fpr_pending[lsu_fp_waddr]);
        end
    end
endmodule
